// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit.
// master drives the instruction/operands, slave is the unit itself.
interface ex_muldiv_unit_if #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FUNCT_SIZE = 6
);
    logic                  i_valid;
    logic [FUNCT_SIZE-1:0] i_funct;
    logic [DATA_SIZE-1:0]  i_data_a;
    logic [DATA_SIZE-1:0]  i_data_b;
    logic                  i_abort;
    logic                  o_stall;
    logic                  o_busy;
    logic [DATA_SIZE-1:0]  o_result;
    logic [DATA_SIZE-1:0]  o_hi;
    logic [DATA_SIZE-1:0]  o_lo;

    modport master (
        output i_valid, i_funct, i_data_a, i_data_b, i_abort,
        input  o_stall, o_busy, o_result, o_hi, o_lo
    );

    modport slave (
        input  i_valid, i_funct, i_data_a, i_data_b, i_abort,
        output o_stall, o_busy, o_result, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; one bit per cycle,
// state advances on the falling edge like the surrounding pipeline registers.
module ex_muldiv_unit #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FUNCT_SIZE = 6,
    parameter int unsigned CNT_SIZE   = 6
) (
    input  logic              i_clock,
    input  logic              i_reset,
    ex_muldiv_unit_if.slave   bus
);
    localparam int unsigned ACC_SIZE = 2 * DATA_SIZE;

    localparam logic [FUNCT_SIZE-1:0] F_MFHI  = FUNCT_SIZE'('h10);
    localparam logic [FUNCT_SIZE-1:0] F_MTHI  = FUNCT_SIZE'('h11);
    localparam logic [FUNCT_SIZE-1:0] F_MFLO  = FUNCT_SIZE'('h12);
    localparam logic [FUNCT_SIZE-1:0] F_MTLO  = FUNCT_SIZE'('h13);
    localparam logic [FUNCT_SIZE-1:0] F_MULT  = FUNCT_SIZE'('h18);
    localparam logic [FUNCT_SIZE-1:0] F_MULTU = FUNCT_SIZE'('h19);
    localparam logic [FUNCT_SIZE-1:0] F_DIV   = FUNCT_SIZE'('h1A);
    localparam logic [FUNCT_SIZE-1:0] F_DIVU  = FUNCT_SIZE'('h1B);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_SIZE-1:0]   cnt_q, cnt_d;
    logic [ACC_SIZE-1:0]   acc_q, acc_d;
    logic [DATA_SIZE-1:0]  opnd_q, opnd_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [DATA_SIZE-1:0]  hi_q, hi_d;
    logic [DATA_SIZE-1:0]  lo_q, lo_d;

    logic is_mul, is_div, is_long, is_mfhi, is_mflo, is_mthi, is_mtlo, is_move;
    logic signed_op, a_neg, b_neg, last_iter;
    logic [DATA_SIZE-1:0] a_mag, b_mag;
    logic [DATA_SIZE:0]   mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [ACC_SIZE-1:0]  mul_step, div_step, prod_signed;

    // Opcode decode and operand magnitudes
    always_comb begin
        is_mul    = (bus.i_funct == F_MULT) || (bus.i_funct == F_MULTU);
        is_div    = (bus.i_funct == F_DIV)  || (bus.i_funct == F_DIVU);
        is_long   = is_mul || is_div;
        is_mfhi   = (bus.i_funct == F_MFHI);
        is_mflo   = (bus.i_funct == F_MFLO);
        is_mthi   = (bus.i_funct == F_MTHI);
        is_mtlo   = (bus.i_funct == F_MTLO);
        is_move   = is_mfhi || is_mflo || is_mthi || is_mtlo;
        signed_op = (bus.i_funct == F_MULT) || (bus.i_funct == F_DIV);
        a_neg     = signed_op && bus.i_data_a[DATA_SIZE-1];
        b_neg     = signed_op && bus.i_data_b[DATA_SIZE-1];
        a_mag     = a_neg ? -bus.i_data_a : bus.i_data_a;
        b_mag     = b_neg ? -bus.i_data_b : bus.i_data_b;
    end

    // One iteration of each algorithm: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[ACC_SIZE-1:DATA_SIZE]} + {1'b0, opnd_q};
        mul_step  = acc_q[0] ? {mul_sum, acc_q[DATA_SIZE-1:1]} : (acc_q >> 1);
        div_shift = {acc_q[ACC_SIZE-1:DATA_SIZE], acc_q[DATA_SIZE-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_step  = {(div_ge ? div_diff[DATA_SIZE-1:0] : div_shift[DATA_SIZE-1:0]),
                     acc_q[DATA_SIZE-2:0], div_ge};
        prod_signed = q_neg_q ? -mul_step : mul_step;
        last_iter   = (cnt_q == CNT_SIZE'(DATA_SIZE - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid && is_long) begin
                    acc_d   = {{DATA_SIZE{1'b0}}, (is_mul ? b_mag : a_mag)};
                    opnd_d  = is_mul ? a_mag : b_mag;
                    // Zero divisor keeps an all-ones quotient unsigned-looking
                    q_neg_d = (a_neg ^ b_neg) && (|bus.i_data_b);
                    r_neg_d = a_neg;
                    cnt_d   = '0;
                    state_d = is_mul ? MUL : DIV;
                end else if (bus.i_valid && is_mthi) begin
                    hi_d = bus.i_data_a;
                end else if (bus.i_valid && is_mtlo) begin
                    lo_d = bus.i_data_a;
                end
            end
            MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CNT_SIZE'(1);
                if (last_iter) begin
                    state_d = DONE;
                    hi_d    = prod_signed[ACC_SIZE-1:DATA_SIZE];
                    lo_d    = prod_signed[DATA_SIZE-1:0];
                end
            end
            DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CNT_SIZE'(1);
                if (last_iter) begin
                    state_d = DONE;
                    lo_d    = q_neg_q ? -div_step[DATA_SIZE-1:0] : div_step[DATA_SIZE-1:0];
                    hi_d    = r_neg_q ? -div_step[ACC_SIZE-1:DATA_SIZE]
                                      : div_step[ACC_SIZE-1:DATA_SIZE];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.i_abort) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(negedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall and move-from result are combinational so the pipeline sees them in the same cycle
    always_comb begin
        bus.o_stall  = bus.i_valid && (is_long || is_move) && (state_q != DONE)
                       && ((state_q != IDLE) || is_long);
        bus.o_busy   = (state_q == MUL) || (state_q == DIV);
        bus.o_result = '0;
        if (bus.i_valid && ((state_q == IDLE) || (state_q == DONE))) begin
            if (is_mfhi)      bus.o_result = hi_q;
            else if (is_mflo) bus.o_result = lo_q;
        end
        bus.o_hi = hi_q;
        bus.o_lo = lo_q;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, sitting directly downstream of the ID/EX pipeline register.
- Consumes the registered funct code and already-forwarded operands, and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers and serves MFHI, MFLO, MTHI and MTLO.
- Raises o_stall, which the pipeline control ANDs into i_pipeline_enable of the upstream pipeline registers until the result is ready.

Parameters:
DATA_SIZE, 32, operand/HI/LO width
FUNCT_SIZE, 6, width of the funct/alu_op code
CNT_SIZE, 6, iteration counter width (must hold DATA_SIZE)

Ports:
i_clock  in  1  system clock; all state updates on the falling edge, matching the pipeline registers
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  EX currently holds a real (non-bubble) instruction
i_funct  in  FUNCT_SIZE  operation code from ID/EX alu_op
i_data_a  in  DATA_SIZE  rs operand (post-forwarding)
i_data_b  in  DATA_SIZE  rt operand (post-forwarding)
i_abort  in  1  synchronous kill of an in-flight operation
o_stall  out  1  high: hold IF/ID and ID/EX, insert bubble into EX/MEM
o_busy  out  1  state is MUL or DIV
o_result  out  DATA_SIZE  MFHI/MFLO value, else 0
o_hi  out  DATA_SIZE  HI register
o_lo  out  DATA_SIZE  LO register

Behaviour:
- Op codes on i_funct:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU (collectively "long ops").
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - Any other code is ignored by this block.
- Reset (async, i_reset=0): state=IDLE, counter=0, HI=LO=0, all datapath registers 0; o_stall=0, o_busy=0, o_result=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - i_valid and a long op: latch operand magnitudes (abs of each for the signed ops, raw for the unsigned ops).
  - Latch result sign: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Clear counter and go to MUL or DIV.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per cycle, DATA_SIZE iterations, then go to DONE.
- DIV: restoring shift-subtract, one quotient bit per cycle, DATA_SIZE iterations, then go to DONE.
- HI/LO write: on the edge entering DONE, apply the latched signs (two's-complement negate) and write HI/LO.
  - MUL: HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient, HI = remainder.
- DONE: unconditionally returns to IDLE on the next edge.
  - The pipeline advances on that same edge, so the op is never restarted.
- o_stall = i_valid & (long op | MF*/MT*) & (state != DONE) & (state != IDLE or op is a long op).
  - Net effect: long ops stall in IDLE, MUL and DIV; MF*/MT* stall only while state is MUL or DIV.
- Latency: a long op stalls for 33 cycles (1 in IDLE + 32 iterations) and sees o_stall=0 in DONE, so it occupies EX for 34 cycles.
- MFHI/MFLO in IDLE or DONE: o_result = HI/LO combinationally, with no stall.
- MTHI/MTLO in IDLE with i_valid: HI/LO <= i_data_a on the edge, with no stall.
- i_valid=0: no state change in IDLE; an in-flight op continues regardless of i_valid.
- Divide by zero: runs the full 32 iterations, then writes LO=0xFFFFFFFF, HI=dividend (raw i_data_a). No exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm; no special case is needed.
- i_abort=1:
  - Any state goes to IDLE on the next edge; HI/LO are unchanged; o_stall drops once in IDLE.
  - Abort wins over a simultaneous start.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.

Test Plan:
- MULTU 7 x 6 → o_stall high 33 cycles; in DONE HI=0x00000000, LO=0x0000002A; next cycle IDLE, o_stall=0.
- MULT 0xFFFFFFFD (−3) x 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF x 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → after 33 stall cycles LO=0xFFFFFFFF, HI=0x00001234.
- MFLO issued 5 cycles into a MULT → o_stall held until DONE; MFLO in IDLE after 3 x 4 gives o_result=12, no stall.
  - MTHI 0xCAFE in IDLE → o_hi=0xCAFE next edge.
- Abort at iteration 10 → IDLE next edge, HI/LO keep their old values.
  - Async reset low mid-DIV → o_busy=0, HI=LO=0 without waiting for a clock edge.
